sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 20, SRAM word address width; DATA_W, 16, SRAM data width.
REQ-002 Ports SHALL be: Clk  in  1  single clock, all logic rising-edge; Reset  in  1  synchronous active-low reset.
REQ-003 Video port SHALL be: v_req in 1 read request; v_addr in ADDR_W; v_ack out 1 one-cycle completion pulse; v_rdata out DATA_W read data.
REQ-004 Game port SHALL be: c_req in 1; c_we in 1 (1=write); c_addr in ADDR_W; c_wdata in DATA_W; c_be in 2 byte enables, [1]=upper, [0]=lower; c_ack out 1; c_rdata out DATA_W.
REQ-005 SRAM port SHALL be: SRAM_ADDR out ADDR_W; SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N out 1 each, active-low; Data_from_SRAM in DATA_W; Data_to_SRAM out DATA_W; SRAM_drive out 1, tristate enable for Data_to_SRAM.
REQ-006 Status port SHALL be: busy out 1, high in every state except IDLE.

Function
REQ-007 FSM states SHALL be IDLE, RD1, RD2, WR1, WR2, WR3, DONE; one transaction in flight at a time.
REQ-008 In IDLE, a pending request SHALL be granted at the rising edge, latching owner, address, we, wdata, be into registers; outputs are driven only from these registers.
REQ-009 Video requests SHALL always be reads with both bytes enabled; c_we=0 requests are reads honouring c_be.
REQ-010 Read: IDLE->RD1->RD2->DONE; CE_N=0, OE_N=0 in RD1 and RD2; Data_from_SRAM captured at end of RD2; ack pulses in DONE; request-to-ack latency 3 cycles.
REQ-011 Write: IDLE->WR1->WR2->WR3->DONE; CE_N=0 and SRAM_drive=1 in WR1..WR3; WE_N=0 only in WR2; OE_N=1 throughout; latency 4 cycles.
REQ-012 UB_N/LB_N SHALL equal inverted latched be during RD1..WR3, and 1 otherwise.
REQ-013 DONE SHALL always return to IDLE; no grant in DONE; minimum spacing between grants 4 cycles (read) or 5 cycles (write).
REQ-014 v_rdata/c_rdata SHALL update only when the respective ack pulses and hold value otherwise; the non-owner's ack/rdata SHALL be unaffected.
REQ-015 Requesters SHALL hold req, addr, data stable until ack; req drop before ack does not abort: transaction completes and ack still pulses.
REQ-016 Simultaneous v_req and c_req in IDLE: video wins (fixed priority), unless REQ-021 applies.
REQ-017 Outside active states: CE_N=OE_N=WE_N=UB_N=LB_N=1, SRAM_drive=0, Data_to_SRAM=latched wdata.

Reset
REQ-018 Reset=0 at a rising edge SHALL force IDLE, all strobes high, SRAM_drive=0, acks=0, busy=0, rdata=0, SRAM_ADDR=0, round-robin pointer = video.
REQ-019 Reset mid-transaction SHALL abort it with no ack; requests still high after Reset returns to 1 are re-arbitrated from IDLE.
REQ-020 Reset SHALL dominate all other inputs in the same cycle.

Configuration
REQ-021 With SRAM_ARB_RR_EN defined, simultaneous requests SHALL alternate: the port not granted last wins; pointer updates on each grant.
REQ-022 Without SRAM_ARB_RR_EN, fixed video priority (REQ-016) applies and no pointer register exists.

Structure
REQ-023 Shared package sram_pkg SHALL hold ADDR_W/DATA_W defaults, the FSM state enum type, and the owner enum (OWN_VIDEO, OWN_GAME).
REQ-024 Design SHALL be a single module; no sub-module.

Verification
REQ-025 Video read: SRAM model holds 0xBEEF at 0x01234, v_req pulse held -> v_ack exactly 3 cycles after grant edge, v_rdata=0xBEEF, OE_N low 2 cycles.
REQ-026 Game write c_addr=0x00010, c_wdata=0xA5C3, c_be=2'b01 -> WE_N low one cycle, LB_N=0, UB_N=1, SRAM_drive 3 cycles, c_ack after 4 cycles; readback yields low byte 0xC3.
REQ-027 Simultaneous v_req and c_req held continuously -> without macro: video granted every time, game starves; with SRAM_ARB_RR_EN: grants alternate V,G,V,G.
REQ-028 Reset driven low during WR2 -> next edge WE_N=1, SRAM_drive=0, state IDLE, no c_ack ever issued for that write.
REQ-029 Back-to-back: c_req re-asserted the cycle after c_ack -> new grant only from IDLE; busy low for exactly one cycle between transactions.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, FSM state and owner types for sram_arbiter.
package sram_pkg;
   localparam int DEF_ADDR_W = 20;
   localparam int DEF_DATA_W = 16;
   typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, WR3, DONE} state_e;
   typedef enum logic {OWN_VIDEO, OWN_GAME} owner_e;
endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter: video/game arbiter for one async SRAM, one transaction in flight.
// SRAM_ARB_RR_EN: round-robin on simultaneous requests (default: fixed video priority).
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              v_req,
   input  logic [ADDR_W-1:0] v_addr,
   output logic              v_ack,
   output logic [DATA_W-1:0] v_rdata,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   input  logic [1:0]        c_be,
   output logic              c_ack,
   output logic [DATA_W-1:0] c_rdata,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   input  logic [DATA_W-1:0] Data_from_SRAM,
   output logic [DATA_W-1:0] Data_to_SRAM,
   output logic              SRAM_drive,
   output logic              busy
);
   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [1:0]          be_q, be_d;
   logic [DATA_W-1:0]   v_rdata_q, v_rdata_d;
   logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
   logic                gnt_v;
   logic                active;
`ifdef SRAM_ARB_RR_EN
   owner_e              rr_q, rr_d;
   assign gnt_v = v_req && (!c_req || rr_q == OWN_VIDEO);
`else
   assign gnt_v = v_req;
`endif
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      v_rdata_d = v_rdata_q;
      c_rdata_d = c_rdata_q;
`ifdef SRAM_ARB_RR_EN
      rr_d      = rr_q;
`endif
      case (state_q)
         IDLE: if (v_req || c_req) begin
            owner_d = gnt_v ? OWN_VIDEO : OWN_GAME;
            addr_d  = gnt_v ? v_addr : c_addr;
            we_d    = !gnt_v && c_we;
            be_d    = gnt_v ? 2'b11 : c_be;
            wdata_d = gnt_v ? wdata_q : c_wdata;
            state_d = we_d ? WR1 : RD1;
`ifdef SRAM_ARB_RR_EN
            rr_d    = gnt_v ? OWN_GAME : OWN_VIDEO;
`endif
         end
         RD1: state_d = RD2;
         RD2: begin
            state_d = DONE;
            if (owner_q == OWN_VIDEO) v_rdata_d = Data_from_SRAM;
            else c_rdata_d = Data_from_SRAM;
         end
         WR1: state_d = WR2;
         WR2: state_d = WR3;
         WR3: state_d = DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q   <= IDLE;
         owner_q   <= OWN_VIDEO;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         be_q      <= '0;
         v_rdata_q <= '0;
         c_rdata_q <= '0;
`ifdef SRAM_ARB_RR_EN
         rr_q      <= OWN_VIDEO;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         v_rdata_q <= v_rdata_d;
         c_rdata_q <= c_rdata_d;
`ifdef SRAM_ARB_RR_EN
         rr_q      <= rr_d;
`endif
      end
   end
   // Strobes are decoded from registered state only, so they never follow request inputs.
   assign active       = state_q inside {RD1, RD2, WR1, WR2, WR3};
   assign SRAM_ADDR    = addr_q;
   assign SRAM_CE_N    = !active;
   assign SRAM_OE_N    = !(state_q inside {RD1, RD2});
   assign SRAM_WE_N    = state_q != WR2;
   assign SRAM_UB_N    = !(active && be_q[1]);
   assign SRAM_LB_N    = !(active && be_q[0]);
   assign SRAM_drive   = state_q inside {WR1, WR2, WR3};
   assign Data_to_SRAM = wdata_q;
   assign busy         = state_q != IDLE;
   assign v_ack        = state_q == DONE && owner_q == OWN_VIDEO;
   assign c_ack        = state_q == DONE && owner_q == OWN_GAME;
   assign v_rdata      = v_rdata_q;
   assign c_rdata      = c_rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: table, random and corner-case checks of sram_arbiter against an SRAM model.
module tb_sram_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        v_req, c_req, c_we;
   logic [19:0] v_addr, c_addr;
   logic [15:0] c_wdata;
   logic [1:0]  c_be;
   logic        v_ack, c_ack;
   logic [15:0] v_rdata, c_rdata;
   logic [19:0] SRAM_ADDR;
   logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_drive, busy;
   logic [15:0] Data_from_SRAM, Data_to_SRAM;
   logic [15:0] mem [0:8191];
   logic [15:0] ref_mem [0:8191];
   logic [15:0] exp_v, exp_c;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   sram_arbiter dut (
      .Clk(clk), .Reset(rst_n),
      .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack), .v_rdata(v_rdata),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
      .c_ack(c_ack), .c_rdata(c_rdata),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
      .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
      .Data_from_SRAM(Data_from_SRAM), .Data_to_SRAM(Data_to_SRAM),
      .SRAM_drive(SRAM_drive), .busy(busy)
   );

   // Async SRAM: disabled byte lanes read back as zero.
   always_comb
      Data_from_SRAM = (!SRAM_CE_N && !SRAM_OE_N) ?
         (mem[SRAM_ADDR[12:0]] & {{8{!SRAM_UB_N}}, {8{!SRAM_LB_N}}}) : 16'h0000;

   always @(posedge clk)
      if (!SRAM_CE_N && !SRAM_WE_N) begin
         if (!SRAM_LB_N) mem[SRAM_ADDR[12:0]][7:0] = Data_to_SRAM[7:0];
         if (!SRAM_UB_N) mem[SRAM_ADDR[12:0]][15:8] = Data_to_SRAM[15:8];
      end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Transaction-level reference: memory array plus per-port last-read value.
   task automatic ref_txn(input bit is_c, input bit we, input logic [19:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be);
      logic [1:0]  e = is_c ? be : 2'b11;
      logic [15:0] m = {{8{e[1]}}, {8{e[0]}}};
      if (is_c && we) ref_mem[addr[12:0]] = (ref_mem[addr[12:0]] & ~m) | (wdata & m);
      else if (is_c) exp_c = ref_mem[addr[12:0]] & m;
      else exp_v = ref_mem[addr[12:0]] & m;
   endtask

   task automatic run_txn(input bit is_c, input bit we, input logic [19:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be,
                          input string tag, output logic [15:0] got);
      int         lat = 0, oe = 0, wen = 0, drv = 0;
      bit         other = 1'b0;
      bit         w = is_c && we;
      logic [1:0] ben = is_c ? ~be : 2'b00;
      ref_txn(is_c, we, addr, wdata, be);
      @(negedge clk);
      if (is_c) begin
         c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; c_be = be;
      end else begin
         v_req = 1'b1; v_addr = addr;
      end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (!SRAM_OE_N) oe++;
         if (!SRAM_WE_N) wen++;
         if (SRAM_drive) drv++;
         if (is_c ? v_ack : c_ack) other = 1'b1;
         if (k == 1) begin
            check({tag, " addr"}, SRAM_ADDR, addr);
            check({tag, " be_n"}, {SRAM_UB_N, SRAM_LB_N}, ben);
         end
         if (is_c ? c_ack : v_ack) begin
            lat = k;
            break;
         end
      end
      v_req = 1'b0;
      c_req = 1'b0;
      check({tag, " latency"}, lat, w ? 4 : 3);
      check({tag, " oe cycles"}, oe, w ? 0 : 2);
      check({tag, " we cycles"}, wen, w ? 1 : 0);
      check({tag, " drive cycles"}, drv, w ? 3 : 0);
      check({tag, " other ack"}, other, 0);
      check({tag, " idle strobes"}, {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 3'b111);
      check({tag, " v_rdata"}, v_rdata, exp_v);
      check({tag, " c_rdata"}, c_rdata, exp_c);
      got = is_c ? c_rdata : v_rdata;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
      exp_v = '0;
      exp_c = '0;
   endtask

   typedef struct {
      bit          is_c;
      bit          we;
      logic [19:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      logic [15:0] exp;
   } vec_t;

   initial begin
      vec_t        tbl [8];
      logic [15:0] got;
      int          got_n, last, idle_n;
      bit          seq [4];
      bit          saw, hit;
      for (int i = 0; i < 8192; i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      exp_v = '0; exp_c = '0;
      v_req = 1'b1; c_req = 1'b1; c_we = 1'b1;
      v_addr = 20'h00055; c_addr = 20'h00066; c_wdata = 16'hFFFF; c_be = 2'b11;
      repeat (3) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
      check("rst drive", SRAM_drive, 0);
      check("rst acks", {v_ack, c_ack}, 2'b00);
      check("rst rdata", {v_rdata, c_rdata}, 32'h0);
      check("rst addr", SRAM_ADDR, 20'h0);
      v_req = 1'b0; c_req = 1'b0; c_we = 1'b0;
      rst_n = 1'b1;

      tbl[0] = '{1'b1, 1'b1, 20'h01234, 16'hBEEF, 2'b11, 16'h0000};
      tbl[1] = '{1'b0, 1'b0, 20'h01234, 16'h0000, 2'b11, 16'hBEEF};
      tbl[2] = '{1'b1, 1'b1, 20'h00010, 16'hA5C3, 2'b01, 16'h0000};
      tbl[3] = '{1'b1, 1'b0, 20'h00010, 16'h0000, 2'b11, 16'h00C3};
      tbl[4] = '{1'b1, 1'b1, 20'h00010, 16'h7700, 2'b10, 16'h0000};
      tbl[5] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 2'b11, 16'h77C3};
      tbl[6] = '{1'b1, 1'b0, 20'h00010, 16'h0000, 2'b10, 16'h7700};
      tbl[7] = '{1'b1, 1'b0, 20'h01234, 16'h0000, 2'b01, 16'h00EF};
      for (int i = 0; i < 8; i++) begin
         run_txn(tbl[i].is_c, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be,
                 $sformatf("vec%0d", i), got);
         if (!tbl[i].we) check($sformatf("vec%0d table rdata", i), got, tbl[i].exp);
      end

      for (int i = 0; i < 40; i++) begin
         bit is_c = 1'($urandom_range(0, 1));
         run_txn(is_c, is_c && 1'($urandom_range(0, 1)), 20'h00100 + 20'($urandom_range(0, 7)),
                 16'($urandom), 2'($urandom_range(0, 3)), $sformatf("rnd%0d", i), got);
      end

      do_reset(2);
      @(negedge clk);
      v_req = 1'b1; v_addr = 20'h01234;
      c_req = 1'b1; c_we = 1'b0; c_addr = 20'h00010; c_be = 2'b11;
      got_n = 0; last = 0;
      for (int k = 1; k <= 80 && got_n < 4; k++) begin
         @(negedge clk);
         if (v_ack || c_ack) begin
            seq[got_n] = c_ack;
            if (got_n > 0) check($sformatf("arb gap%0d", got_n), k - last, 4);
            last = k;
            got_n++;
         end
      end
      v_req = 1'b0; c_req = 1'b0;
      check("arb ack count", got_n, 4);
      for (int i = 0; i < 4; i++)
`ifdef SRAM_ARB_RR_EN
         check($sformatf("arb grant%0d", i), seq[i], i % 2);
`else
         check($sformatf("arb grant%0d", i), seq[i], 0);
`endif

      do_reset(1);
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b1; c_addr = 20'h003FF; c_wdata = 16'h1234; c_be = 2'b11;
      saw = 1'b0; hit = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (c_ack) saw = 1'b1;
         if (!SRAM_WE_N) begin
            hit = 1'b1;
            break;
         end
      end
      check("wr2 reached", hit, 1);
      rst_n = 1'b0;
      c_req = 1'b0;
      @(negedge clk);
      check("wr2 rst we_n", SRAM_WE_N, 1);
      check("wr2 rst drive", SRAM_drive, 0);
      check("wr2 rst busy", busy, 0);
      check("wr2 rst ce_n", SRAM_CE_N, 1);
      rst_n = 1'b1;
      exp_v = '0; exp_c = '0;
      repeat (8) begin
         @(negedge clk);
         if (c_ack) saw = 1'b1;
      end
      check("wr2 no ack", saw, 0);

      exp_c = ref_mem[13'h0010];
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 20'h00010; c_be = 2'b11;
      got_n = 0; last = 0; idle_n = 0;
      for (int k = 1; k <= 40 && got_n < 2; k++) begin
         @(negedge clk);
         if (got_n == 1 && !busy) idle_n++;
         if (c_ack) begin
            if (got_n == 1) check("b2b gap", k - last, 4);
            last = k;
            got_n++;
         end
      end
      c_req = 1'b0;
      check("b2b ack count", got_n, 2);
      check("b2b idle cycles", idle_n, 1);
      check("b2b c_rdata", c_rdata, exp_c);
      check("b2b v_rdata", v_rdata, exp_v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
